lda_cmd_arbiter: RTL

- Shares one line-drawing engine between NUM_REQ command sources, for example the Avalon slave front-end and a hardware screen-clear generator.
- Arbitrates round-robin and latches the winning command (x0, y0, x1, y1, colour).
- Issues a single-cycle start, then holds the grant until the engine reports done or a watchdog expires.
- Sits between the requesters and the engine's ready/start/done/coordinate interface.

---
 rtl/lda_cmd_arbiter_pkg.sv | 15 +
 rtl/lda_cmd_arbiter_if.sv | 24 ++
 rtl/lda_cmd_arbiter_rr_picker.sv | 25 ++
 rtl/lda_cmd_arbiter.sv | 76 +++++++
 4 files changed

// File: rtl/lda_cmd_arbiter_pkg.sv
// lda_pkg: command layout, arbiter states and field widths shared by the line-draw arbiter
package lda_pkg;
    localparam int LDA_X_W = 9;
    localparam int LDA_Y_W = 8;
    localparam int LDA_C_W = 3;
    typedef struct packed {
        logic [LDA_C_W-1:0] colour;
        logic [LDA_Y_W-1:0] y1;
        logic [LDA_X_W-1:0] x1;
        logic [LDA_Y_W-1:0] y0;
        logic [LDA_X_W-1:0] x0;
    } lda_cmd_t;
    localparam int LDA_CMD_W = $bits(lda_cmd_t);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} lda_arb_state_e;
endpackage

// File: rtl/lda_cmd_arbiter_if.sv
// lda_cmd_arbiter_if: requester handshakes plus the engine start/done/coordinate bus
interface lda_cmd_arbiter_if #(parameter int NUM_REQ = 2);
    import lda_pkg::*;
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*LDA_CMD_W-1:0] req_cmd;
    logic [NUM_REQ-1:0]           req_ack;
    logic [NUM_REQ-1:0]           req_done;
    logic                         lda_ready;
    logic                         lda_done;
    logic                         lda_start;
    logic [LDA_X_W-1:0]           lda_x0;
    logic [LDA_Y_W-1:0]           lda_y0;
    logic [LDA_X_W-1:0]           lda_x1;
    logic [LDA_Y_W-1:0]           lda_y1;
    logic [LDA_C_W-1:0]           lda_colour;
    modport master (
        input  req_valid, req_cmd, lda_ready, lda_done,
        output req_ack, req_done, lda_start, lda_x0, lda_y0, lda_x1, lda_y1, lda_colour
    );
    modport slave (
        output req_valid, req_cmd, lda_ready, lda_done,
        input  req_ack, req_done, lda_start, lda_x0, lda_y0, lda_x1, lda_y1, lda_colour
    );
endinterface

// File: rtl/lda_cmd_arbiter_rr_picker.sv
// rr_picker: picks the first requester at or after ptr, wrapping, as one-hot grant and index
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [GW-1:0]      idx,
    output logic               any
);
    int best;
    // smallest wrapped distance from ptr wins
    always_comb begin
        best = NUM_REQ;
        idx  = '0;
        for (int j = 0; j < NUM_REQ; j++)
            if (req[j] && (j + NUM_REQ - int'(ptr)) % NUM_REQ < best) begin
                best = (j + NUM_REQ - int'(ptr)) % NUM_REQ;
                idx  = GW'(j);
            end
    end
    assign any   = |req;
    assign grant = any ? NUM_REQ'(1) << idx : '0;
endmodule

// File: rtl/lda_cmd_arbiter.sv
// lda_cmd_arbiter: round-robin share of one line-draw engine, with command latch and watchdog
module lda_cmd_arbiter
    import lda_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    parameter  int TIMEOUT = 1048576,
    localparam int GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    lda_cmd_arbiter_if.master    bus,
    output logic                 busy,
    output logic [GW-1:0]        grant_id,
    output logic                 timeout_err,
    input  logic                 err_clr
);
    lda_arb_state_e     state, nxt;
    logic [GW-1:0]      rr_ptr, win_idx;
    logic [NUM_REQ-1:0] win_grant;
    logic               any, win, fire, fin, last;
    logic [CW-1:0]      cnt;
    lda_cmd_t           cmd, sel;

    rr_picker #(.NUM_REQ(NUM_REQ), .GW(GW)) u_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (win_grant),
        .idx   (win_idx),
        .any   (any)
    );

    always_comb begin
        sel = '0;
        for (int j = 0; j < NUM_REQ; j++)
            if (win_idx == GW'(j)) sel = bus.req_cmd[j*LDA_CMD_W +: LDA_CMD_W];
        last = cnt == CW'(TIMEOUT - 1);
        win  = state == IDLE && any;
        fire = state == ISSUE && bus.lda_ready;
        fin  = state == WAIT_DONE && (bus.lda_done || last);
        nxt  = win ? ISSUE : fire ? WAIT_DONE : fin ? IDLE : state;
    end

    // a done on the terminal count finishes cleanly, so the error only latches without it
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            cnt           <= '0;
            cmd           <= '0;
            grant_id      <= '0;
            timeout_err   <= 1'b0;
            bus.req_ack   <= '0;
            bus.req_done  <= '0;
            bus.lda_start <= 1'b0;
        end else begin
            state         <= nxt;
            cnt           <= state == WAIT_DONE ? cnt + 1'b1 : '0;
            bus.req_ack   <= win ? win_grant : '0;
            bus.lda_start <= fire;
            bus.req_done  <= fin ? NUM_REQ'(1) << grant_id : '0;
            timeout_err   <= (fin && !bus.lda_done) || (timeout_err && !err_clr);
            if (win) begin
                cmd      <= sel;
                grant_id <= win_idx;
            end
            if (fin) rr_ptr <= grant_id == GW'(NUM_REQ - 1) ? '0 : grant_id + 1'b1;
        end

    assign busy           = state != IDLE;
    assign bus.lda_x0     = cmd.x0;
    assign bus.lda_y0     = cmd.y0;
    assign bus.lda_x1     = cmd.x1;
    assign bus.lda_y1     = cmd.y1;
    assign bus.lda_colour = cmd.colour;
endmodule
